// File: rtl/max7219_pkg.sv
// Shared definitions for the MAX7219 serial link: register addresses, frame size
// and the receiver FSM encoding.
package max7219_pkg;

  localparam int FRAME_BITS = 16;

  localparam logic [3:0] NOOP      = 4'h0;
  localparam logic [3:0] DIGIT0    = 4'h1;
  localparam logic [3:0] DIGIT1    = 4'h2;
  localparam logic [3:0] DIGIT2    = 4'h3;
  localparam logic [3:0] DIGIT3    = 4'h4;
  localparam logic [3:0] DIGIT4    = 4'h5;
  localparam logic [3:0] DIGIT5    = 4'h6;
  localparam logic [3:0] DIGIT6    = 4'h7;
  localparam logic [3:0] DIGIT7    = 4'h8;
  localparam logic [3:0] DECODE    = 4'h9;
  localparam logic [3:0] INTENSITY = 4'hA;
  localparam logic [3:0] SCANLIMIT = 4'hB;
  localparam logic [3:0] SHUTDOWN  = 4'hC;
  localparam logic [3:0] TEST      = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_LATCH = 2'd2
  } rx_state_e;

endpackage

// File: rtl/sync_edge_detect.sv
// Multi-flop synchroniser for one asynchronous input, with one extra flop
// providing single-cycle rise/fall pulses on the synchronised level.
module sync_edge_detect #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_VAL   = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_async,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  // NOTE: non-blocking assignments make every flop sample its predecessor's old
  // value, so the chain really delays by SYNC_STAGES cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= {SYNC_STAGES{RESET_VAL}};
      r_prev <= RESET_VAL;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_level = r_sync[SYNC_STAGES-1];
  assign o_rise  = o_level & ~r_prev;
  assign o_fall  = ~o_level & r_prev;

endmodule

// File: rtl/max7219_spi_receiver.sv
// Receiving end of the MAX7219 3-wire link: deserialises 16-bit frames and keeps
// a MAX7219-equivalent register file (8 digit rows plus control registers).
module max7219_spi_receiver
  import max7219_pkg::*;
#(
  parameter int   SYNC_STAGES    = 2,
  parameter logic RESET_SHUTDOWN = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       spi_din,
  input  logic       spi_cs,
  input  logic       spi_sclk,
  output logic       spi_dout,
  output logic       frame_valid,
  output logic [3:0] frame_addr,
  output logic [7:0] frame_data,
  output logic       frame_err,
  input  logic [2:0] row_sel,
  output logic [7:0] row_data,
  output logic [7:0] decode_mode,
  output logic [3:0] intensity,
  output logic [2:0] scan_limit,
  output logic       shutdown,
  output logic       display_test
);

  logic w_cs_rise, w_cs_fall, w_cs_level_unused;
  logic w_sclk_rise, w_sclk_level_unused, w_sclk_fall_unused;
  logic w_din, w_din_rise_unused, w_din_fall_unused;

  sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
    .clk(clk), .rst_n(rst_n), .i_async(spi_cs),
    .o_level(w_cs_level_unused), .o_rise(w_cs_rise), .o_fall(w_cs_fall)
  );

  sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rst_n(rst_n), .i_async(spi_sclk),
    .o_level(w_sclk_level_unused), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall_unused)
  );

  sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_din (
    .clk(clk), .rst_n(rst_n), .i_async(spi_din),
    .o_level(w_din), .o_rise(w_din_rise_unused), .o_fall(w_din_fall_unused)
  );

  rx_state_e   r_state, w_state_nxt;
  logic        w_clear, w_shift_en, w_commit, w_reject;
  logic [15:0] r_shift;
  logic [4:0]  r_bit_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // NOTE: every signal gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_clear     = 1'b0;
    w_shift_en  = 1'b0;
    w_commit    = 1'b0;
    w_reject    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_cs_fall) begin
          w_clear     = 1'b1;
          w_state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        // A coincident sclk edge is still shifted in as the frame closes.
        w_shift_en = w_sclk_rise;
        if (w_cs_rise) w_state_nxt = ST_LATCH;
      end
      ST_LATCH: begin
        w_state_nxt = ST_IDLE;
        if (r_bit_cnt >= 5'(FRAME_BITS)) w_commit = 1'b1;
        else                             w_reject = 1'b1;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift   <= '0;
      r_bit_cnt <= '0;
    end else if (w_clear) begin
      r_shift   <= '0;
      r_bit_cnt <= '0;
    end else if (w_shift_en) begin
      r_shift <= {r_shift[14:0], w_din};
      if (r_bit_cnt != 5'd31) r_bit_cnt <= r_bit_cnt + 5'd1;
    end
  end

  assign spi_dout = r_shift[15];

  logic [3:0] w_addr;
  logic [7:0] w_data;
  logic [2:0] w_row_idx;
  logic       w_is_row;

  assign w_addr    = r_shift[11:8];
  assign w_data    = r_shift[7:0];
  assign w_row_idx = 3'(w_addr - DIGIT0);
  assign w_is_row  = (w_addr >= DIGIT0) && (w_addr <= DIGIT7);

  logic [7:0] r_rows [8];
  logic       r_frame_valid, r_frame_err, r_shutdown, r_display_test;
  logic [3:0] r_frame_addr, r_intensity;
  logic [7:0] r_frame_data, r_decode_mode, r_row_data;
  logic [2:0] r_scan_limit;

  // NOTE: the row array is reset explicitly because rows must read 0x00 after
  // reset; this costs a reset net per bit, so it stays flops rather than RAM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) r_rows[i] <= '0;
      r_frame_valid  <= 1'b0;
      r_frame_err    <= 1'b0;
      r_frame_addr   <= '0;
      r_frame_data   <= '0;
      r_decode_mode  <= '0;
      r_intensity    <= '0;
      r_scan_limit   <= '0;
      r_shutdown     <= RESET_SHUTDOWN;
      r_display_test <= 1'b0;
      r_row_data     <= '0;
    end else begin
      r_frame_valid <= w_commit;
      r_frame_err   <= w_reject;
      r_row_data    <= r_rows[row_sel];
      if (w_commit) begin
        r_frame_addr <= w_addr;
        r_frame_data <= w_data;
        case (w_addr)
          DECODE:    r_decode_mode  <= w_data;
          INTENSITY: r_intensity    <= w_data[3:0];
          SCANLIMIT: r_scan_limit   <= w_data[2:0];
          SHUTDOWN:  r_shutdown     <= ~w_data[0];
          TEST:      r_display_test <= w_data[0];
          default:   if (w_is_row) r_rows[w_row_idx] <= w_data;
        endcase
      end
    end
  end

  assign frame_valid  = r_frame_valid;
  assign frame_err    = r_frame_err;
  assign frame_addr   = r_frame_addr;
  assign frame_data   = r_frame_data;
  assign row_data     = r_row_data;
  assign decode_mode  = r_decode_mode;
  assign intensity    = r_intensity;
  assign scan_limit   = r_scan_limit;
  assign shutdown     = r_shutdown;
  assign display_test = r_display_test;

endmodule
